mandelbrot_sched: RTL
=====================

Name: mandelbrot_sched

Overview:
- Shares NCORES mandelbrot_calc iteration engines between one coordinate job stream and one result stream.
- Dispatches each incoming (x, y, address) job to a free engine, chosen round-robin.
- Collects finished engines round-robin into a registered result stream for the framebuffer writer.
- Sits between the coordinate generator and the iteration-count store.
- Tracks the number of outstanding jobs and exposes an idle flag for frame-done detection.

Parameters:
- NCORES, 4: number of attached engines (2..16).
- MAXITERS, 256: engine iteration limit; sets IW.
- IW, $clog2(MAXITERS): iteration-count width.
- FPW, 54: fixed-point coordinate width.
- AW, 11: address width.
- CW, $clog2(NCORES+1): outstanding-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- clk_en  in  1  global clock enable; the same signal drives every engine.
- job_vld  in  1  job valid.
- job_rdy  out  1  job accepted this cycle when job_vld is also high.
- job_x  in  FPW  Mandelbrot x coordinate.
- job_y  in  FPW  Mandelbrot y coordinate.
- job_adr  in  AW  pixel address.
- core_in_vld  out  NCORES  one-hot dispatch strobe, one bit per engine.
- core_in_rdy  in  NCORES  engine idle flags.
- core_x  out  FPW  broadcast x coordinate.
- core_y  out  FPW  broadcast y coordinate.
- core_adr  out  AW  broadcast address.
- core_out_vld  in  NCORES  engine result valid.
- core_out_rdy  out  NCORES  one-hot result acknowledge.
- core_niter  in  NCORES*IW  packed engine counts; engine k occupies bits [k*IW +: IW].
- core_adr_o  in  NCORES*AW  packed engine addresses; engine k occupies bits [k*AW +: AW].
- res_vld  out  1  result valid.
- res_rdy  in  1  downstream accept.
- res_niter  out  IW  iteration count.
- res_adr  out  AW  pixel address.
- outstanding  out  CW  jobs dispatched but not yet collected.
- idle  out  1  high when outstanding==0 and res_vld==0.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset clears res_vld, res_niter, res_adr, outstanding, dptr and cptr to 0; idle=1.
- Nothing advances while clk_en=0. job_rdy, core_in_vld and core_out_rdy are all forced to 0.

Dispatch (combinational, zero latency):
- Dispatch grant dg = the first index, scanning dptr, dptr+1, … modulo NCORES, whose core_in_rdy=1.
- job_rdy = clk_en & (any core_in_rdy).
- core_in_vld[dg] = job_vld & job_rdy; all other bits are 0.
- core_x, core_y and core_adr = job_x, job_y and job_adr, unconditionally.
- On a dispatch, dptr <= dg+1 (mod NCORES).
- After a dispatch the engine drops core_in_rdy on the next enabled edge, so no engine is granted twice.

Collect:
- Collect grant cg = the first index, scanning cptr onward modulo NCORES, whose core_out_vld=1.
- take = clk_en & (any core_out_vld) & (!res_vld | res_rdy).
- core_out_rdy[cg] = take, a single-cycle pulse.
- On take: res_niter and res_adr <= the slice of engine cg; res_vld <= 1; cptr <= cg+1 (mod NCORES).
- On clk_en & res_vld & res_rdy & !take: res_vld <= 0.
- Result latency: engine out_vld to res_vld is 1 cycle when the output register is free.
- Full throughput is one result per cycle when res_rdy is held high.
- res_niter and res_adr stay stable while res_vld=1 and res_rdy=0.

Outstanding counter:
- Dispatch only: +1. take only: −1. Both in the same cycle: unchanged.
- It never exceeds NCORES and never goes below 0. A violation is a design error; the bench asserts against it.

Boundary conditions:
- All engines busy: job_rdy=0 and the job is held upstream.
- Several engines finish together: they are served in round-robin order, one per enabled cycle. Each waiting engine keeps its out_vld high until acknowledged.
- Reset mid-frame: scheduler state is cleared. Engines are reset by the same rst, so no stale results can appear.

Test Plan:
- NCORES=4, all idle, 4 back-to-back jobs with adr 0..3 → core_in_vld sequence 0001, 0010, 0100, 1000; job_rdy=0 on the 5th job; outstanding=4.
- Engines 1 and 3 assert core_out_vld in the same cycle with cptr=2, res_rdy=1 → engine 3 is collected first, engine 1 on the next cycle; res_adr follows the same order; outstanding goes 4→3→2.
- res_rdy=0 with res_vld=1 and engine 0 done → core_out_rdy stays 0000 and res_niter/res_adr stay stable; when res_rdy is raised, engine 0 is acked in that same cycle.
- Simultaneous dispatch to engine 2 and collect from engine 0 → outstanding unchanged at 3; both one-hot strobes are correct.
- clk_en=0 for 5 cycles with pending jobs and results → no strobes and no state change; activity resumes on the first clk_en=1 cycle.
- rst asserted mid-frame with outstanding=3 and res_vld=1 → res_vld=0, outstanding=0 and idle=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mandelbrot_sched.sv
// Round-robin scheduler sharing NCORES iteration engines between one job stream and one result stream.
// Dispatch is combinational; collect has one register stage; stalls upstream when all engines are busy and holds results while res_rdy=0.
module mandelbrot_sched #(
  parameter int NCORES   = 4,
  parameter int MAXITERS = 256,
  parameter int IW       = $clog2(MAXITERS),
  parameter int FPW      = 54,
  parameter int AW       = 11,
  parameter int CW       = $clog2(NCORES+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 job_vld,
  output logic                 job_rdy,
  input  logic [FPW-1:0]       job_x,
  input  logic [FPW-1:0]       job_y,
  input  logic [AW-1:0]        job_adr,
  output logic [NCORES-1:0]    core_in_vld,
  input  logic [NCORES-1:0]    core_in_rdy,
  output logic [FPW-1:0]       core_x,
  output logic [FPW-1:0]       core_y,
  output logic [AW-1:0]        core_adr,
  input  logic [NCORES-1:0]    core_out_vld,
  output logic [NCORES-1:0]    core_out_rdy,
  input  logic [NCORES*IW-1:0] core_niter,
  input  logic [NCORES*AW-1:0] core_adr_o,
  output logic                 res_vld,
  input  logic                 res_rdy,
  output logic [IW-1:0]        res_niter,
  output logic [AW-1:0]        res_adr,
  output logic [CW-1:0]        outstanding,
  output logic                 idle
);

  localparam int PW = $clog2(NCORES);
  localparam logic [PW-1:0] LAST = PW'(NCORES-1);

  // First requester at or after ptr, wrapping modulo NCORES.
  function automatic logic [PW-1:0] rr_pick(input logic [NCORES-1:0] req, input logic [PW-1:0] ptr);
    logic [PW-1:0] g;
    logic          found;
    int            k;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      k = int'(ptr) + i;
      if (k >= NCORES) k = k - NCORES;
      if (!found && req[k]) begin
        found = 1'b1;
        g     = PW'(k);
      end
    end
    return g;
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] g);
    return (g == LAST) ? '0 : g + 1'b1;
  endfunction

  logic [PW-1:0] dptr, cptr;
  logic [PW-1:0] dg, cg;
  logic          dispatch, take;

  assign dg       = rr_pick(core_in_rdy, dptr);
  assign cg       = rr_pick(core_out_vld, cptr);
  assign job_rdy  = clk_en & (|core_in_rdy);
  assign dispatch = job_vld & job_rdy;
  assign take     = clk_en & (|core_out_vld) & (~res_vld | res_rdy);

  always_comb begin
    core_in_vld      = '0;
    core_out_rdy     = '0;
    core_in_vld[dg]  = dispatch;
    core_out_rdy[cg] = take;
  end

  assign core_x   = job_x;
  assign core_y   = job_y;
  assign core_adr = job_adr;
  assign idle     = (outstanding == '0) & ~res_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld     <= 1'b0;
      res_niter   <= '0;
      res_adr     <= '0;
      outstanding <= '0;
      dptr        <= '0;
      cptr        <= '0;
    end else if (clk_en) begin
      if (dispatch) dptr <= rr_next(dg);
      if (take) begin
        res_vld   <= 1'b1;
        res_niter <= core_niter[int'(cg)*IW +: IW];
        res_adr   <= core_adr_o[int'(cg)*AW +: AW];
        cptr      <= rr_next(cg);
      end else if (res_vld && res_rdy) begin
        res_vld <= 1'b0;
      end
      // A dispatch and a collect in the same cycle cancel out.
      case ({dispatch, take})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
